cxu_responder: RTL and testbench
================================

Name: cxu_responder

Overview:
- Responder-side CXU (custom function unit) that accepts requests from the cva5 CXU requester port and returns in-order responses.
- Implements a small integer function set, including a per-state accumulator, behind a fixed-latency pipeline and a response FIFO with backpressure.
- Sits outside the core wrapper and connects directly to the cxu_req_* / cxu_resp_* ports.

Parameters:
- CXU_ID, 0: identifier this unit answers to.
- REQ_ID_W, 3: request ID width.
- CXU_ID_W, 4: CXU ID width.
- STATE_ID_W, 2: state ID width; there are 2^STATE_ID_W accumulators.
- FUNC_ID_W, 3: function ID width.
- INSN_W, 32: instruction width; the field is ignored.
- DATA_W, 32: operand/result width.
- STATUS_W, 2: response status width.
- LATENCY, 2: pipeline stages from accept to FIFO, ≥1.
- DEPTH, 4: maximum outstanding requests (pipeline + FIFO); power of 2, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cxu_req_valid  in  1  request valid
- cxu_req_ready  out  1  request accept
- cxu_req_id  in  REQ_ID_W  request tag
- cxu_req_cxu  in  CXU_ID_W  target CXU
- cxu_req_state  in  STATE_ID_W  accumulator select
- cxu_req_func  in  FUNC_ID_W  function code
- cxu_req_insn  in  INSN_W  raw instruction (unused)
- cxu_req_data0  in  DATA_W  operand A
- cxu_req_data1  in  DATA_W  operand B
- cxu_resp_valid  out  1  response valid
- cxu_resp_ready  in  1  response accept
- cxu_resp_id  out  REQ_ID_W  echoed tag
- cxu_resp_status  out  STATUS_W  0 OK, 1 ERR_FUNC, 2 ERR_CXU
- cxu_resp_data  out  DATA_W  result

Behaviour:
- Handshakes: a request is accepted when req_valid && req_ready. A response is consumed when resp_valid && resp_ready.
- Once asserted, resp_valid and the resp_* fields hold stable until consumed.
- req_ready = (inflight + fifo_count) < DEPTH, a registered count. It must not depend combinationally on req_valid.
- A pop in the same cycle frees a slot for the next cycle, not the current one.
- Functions (all arithmetic mod 2^DATA_W):
  - 0 ADD: A+B.
  - 1 XOR: A^B.
  - 2 POPCNT: ones count of A, zero-extended.
  - 3 MAC: acc[s] <= acc[s] + low DATA_W bits of A*B; returns the new acc.
  - 4 RDACC: returns acc[s].
  - 5 WRACC: acc[s] <= A; returns the old acc.
  - 6 and 7: status ERR_FUNC, data 0, no state change.
- CXU ID check: if req_cxu != CXU_ID, status is ERR_CXU, data 0, no state change. This takes priority over ERR_FUNC. Every accepted request produces exactly one response.
- Accumulator timing: accumulator read/update happens in the accept cycle. Back-to-back MAC/WRACC/RDACC on the same state therefore see each other's effects with no hazard.
- Latency: a request accepted in cycle t writes the FIFO at the end of cycle t+LATENCY-1. If the FIFO is otherwise empty, resp_valid is high in cycle t+LATENCY.
- Ordering: responses are strictly in acceptance order. resp_id equals the accepted req_id.
- Throughput: one request per cycle sustained while resp_ready stays high.
- FIFO boundaries:
  - Push and pop in the same cycle are legal, including when full.
  - Pointers wrap modulo DEPTH.
  - The full/empty distinction uses the count.
- Backpressure: with resp_ready low, the unit accepts exactly DEPTH requests, then req_ready drops. No result is dropped.
- Reset (asynchronous, at any time):
  - All acc = 0.
  - Pipeline valids cleared, FIFO emptied, counts = 0.
  - resp_valid = 0, resp_id/status/data = 0.
  - req_ready = 0 while rst is high, then 1 in the first cycle after rst deasserts.
  - In-flight requests at reset are discarded without response.

Test Plan:
- Post-reset ADD: req id=3, func=0, A=0xFFFF_FFFF, B=2 at cycle t → resp_valid at t+2, id=3, status=0, data=0x0000_0001.
- MAC chain on state 1: WRACC A=10 (returns 0), then MAC A=3 B=4, then MAC A=5 B=5 back-to-back → data 10, 22, 47. RDACC state 0 → 0.
- Error paths: func=6 → status 1, data 0; cxu=5 with func=6 → status 2; a following RDACC confirms acc unchanged.
- Backpressure: hold resp_ready=0, drive valid every cycle → exactly 4 accepts, then req_ready=0. Release → 4 responses in order with ids 0..3; req_ready reasserts the cycle after the first pop.
- Streaming: resp_ready=1, 16 consecutive POPCNT requests with A=(1<<k)-1 for k=0..15 → 16 responses on consecutive cycles, data=k, ids wrapping 0..7,0..7.
- Reset mid-flight: accept 3 requests, assert rst before the first response → resp_valid=0, no stale responses after release, acc read back as 0.

Source files
------------

// File: rtl/cxu_responder.sv
// cxu_responder: CXU responder with per-state accumulators,
// a fixed-latency result pipeline and an in-order response FIFO.
module cxu_responder #(
  parameter int CXU_ID     = 0,
  parameter int REQ_ID_W   = 3,
  parameter int CXU_ID_W   = 4,
  parameter int STATE_ID_W = 2,
  parameter int FUNC_ID_W  = 3,
  parameter int INSN_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STATUS_W   = 2,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cxu_req_valid,
  output logic                  cxu_req_ready,
  input  logic [REQ_ID_W-1:0]   cxu_req_id,
  input  logic [CXU_ID_W-1:0]   cxu_req_cxu,
  input  logic [STATE_ID_W-1:0] cxu_req_state,
  input  logic [FUNC_ID_W-1:0]  cxu_req_func,
  input  logic [INSN_W-1:0]     cxu_req_insn,
  input  logic [DATA_W-1:0]     cxu_req_data0,
  input  logic [DATA_W-1:0]     cxu_req_data1,
  output logic                  cxu_resp_valid,
  input  logic                  cxu_resp_ready,
  output logic [REQ_ID_W-1:0]   cxu_resp_id,
  output logic [STATUS_W-1:0]   cxu_resp_status,
  output logic [DATA_W-1:0]     cxu_resp_data
);

  localparam int NACC = 1 << STATE_ID_W;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int PCW  = $clog2(DATA_W + 1);

  localparam logic [STATUS_W-1:0] ST_OK    = STATUS_W'(0);
  localparam logic [STATUS_W-1:0] ST_EFUNC = STATUS_W'(1);
  localparam logic [STATUS_W-1:0] ST_ECXU  = STATUS_W'(2);

  localparam logic [FUNC_ID_W-1:0] F_ADD   = FUNC_ID_W'(0);
  localparam logic [FUNC_ID_W-1:0] F_XOR   = FUNC_ID_W'(1);
  localparam logic [FUNC_ID_W-1:0] F_POP   = FUNC_ID_W'(2);
  localparam logic [FUNC_ID_W-1:0] F_MAC   = FUNC_ID_W'(3);
  localparam logic [FUNC_ID_W-1:0] F_RDACC = FUNC_ID_W'(4);
  localparam logic [FUNC_ID_W-1:0] F_WRACC = FUNC_ID_W'(5);

  typedef struct packed {
    logic [REQ_ID_W-1:0] id;
    logic [STATUS_W-1:0] status;
    logic [DATA_W-1:0]   data;
  } resp_t;

  logic [NACC-1:0][DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_cur;
  logic [DATA_W-1:0] mac_sum;
  logic [PCW-1:0]    ones;
  logic              cxu_hit;
  logic              accept;
  logic              push;
  logic              pop;
  resp_t             res;
  resp_t             push_e;
  logic [CW-1:0]     out_cnt;
  logic [CW-1:0]     out_cnt_nx;
  logic              rdy_q;
  logic              unused_insn;

  assign unused_insn   = ^cxu_req_insn;
  assign cxu_req_ready = rdy_q;
  assign accept        = cxu_req_valid & rdy_q;
  assign cxu_hit       = cxu_req_cxu == CXU_ID_W'(CXU_ID);
  assign acc_cur       = acc[cxu_req_state];
  assign mac_sum       = acc_cur + cxu_req_data0 * cxu_req_data1;

  always_comb begin
    ones = '0;
    for (int i = 0; i < DATA_W; i++)
      ones = ones + PCW'(cxu_req_data0[i]);
  end

  // Result is formed in the accept cycle, so acc effects are immediate.
  always_comb begin
    res    = '0;
    res.id = cxu_req_id;
    if (!cxu_hit) begin
      res.status = ST_ECXU;
    end else begin
      unique case (cxu_req_func)
        F_ADD:   res.data = cxu_req_data0 + cxu_req_data1;
        F_XOR:   res.data = cxu_req_data0 ^ cxu_req_data1;
        F_POP:   res.data = DATA_W'(ones);
        F_MAC:   res.data = mac_sum;
        F_RDACC: res.data = acc_cur;
        F_WRACC: res.data = acc_cur;
        default: res.status = ST_EFUNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (accept && cxu_hit) begin
      if (cxu_req_func == F_MAC)
        acc[cxu_req_state] <= mac_sum;
      else if (cxu_req_func == F_WRACC)
        acc[cxu_req_state] <= cxu_req_data0;
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign push   = accept;
      assign push_e = res;
    end else begin : g_pipe
      localparam int NS = LATENCY - 1;
      logic  [NS-1:0] pv;
      resp_t [NS-1:0] pd;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pv <= '0;
          pd <= '0;
        end else begin
          pv[0] <= accept;
          pd[0] <= res;
          for (int i = 1; i < NS; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end
      assign push   = pv[NS-1];
      assign push_e = pd[NS-1];
    end
  endgenerate

  // Outstanding count bounds pipeline + FIFO, so a push never overflows.
  resp_t [DEPTH-1:0] mem;
  logic  [PW-1:0]    wr_ptr;
  logic  [PW-1:0]    rd_ptr;
  logic  [CW-1:0]    f_cnt;
  resp_t             head;

  assign head            = mem[rd_ptr];
  assign cxu_resp_valid  = f_cnt != '0;
  assign cxu_resp_id     = head.id;
  assign cxu_resp_status = head.status;
  assign cxu_resp_data   = head.data;
  assign pop             = cxu_resp_valid & cxu_resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      f_cnt  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_e;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      f_cnt <= f_cnt + CW'(push) - CW'(pop);
    end
  end

  assign out_cnt_nx = out_cnt + CW'(accept) - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= '0;
      rdy_q   <= 1'b0;
    end else begin
      out_cnt <= out_cnt_nx;
      rdy_q   <= out_cnt_nx < CW'(DEPTH);
    end
  end

endmodule

// File: tb/tb_cxu_responder.sv
// tb_cxu_responder: scoreboard bench for cxu_responder with a
// queue/array reference model and randomized plus directed stimulus.
module tb_cxu_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_id = '0;
  logic [3:0]  req_cxu = '0;
  logic [1:0]  req_state = '0;
  logic [2:0]  req_func = '0;
  logic [31:0] req_insn = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [2:0]  resp_id;
  logic [1:0]  resp_status;
  logic [31:0] resp_data;

  cxu_responder dut (
    .clk             (clk),
    .rst             (rst),
    .cxu_req_valid   (req_valid),
    .cxu_req_ready   (req_ready),
    .cxu_req_id      (req_id),
    .cxu_req_cxu     (req_cxu),
    .cxu_req_state   (req_state),
    .cxu_req_func    (req_func),
    .cxu_req_insn    (req_insn),
    .cxu_req_data0   (req_a),
    .cxu_req_data1   (req_b),
    .cxu_resp_valid  (resp_valid),
    .cxu_resp_ready  (resp_ready),
    .cxu_resp_id     (resp_id),
    .cxu_resp_status (resp_status),
    .cxu_resp_data   (resp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  id;
    logic [1:0]  st;
    logic [31:0] d;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          pop_cyc[$];
  int unsigned macc[4];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          acc_cyc = 0;
  bit          rand_rr = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference behaviour: plain arithmetic on an accumulator array.
  function automatic exp_t model(logic [2:0] id, logic [3:0] cxu,
                                 logic [1:0] s, logic [2:0] f,
                                 logic [31:0] a, logic [31:0] b);
    exp_t e;
    e.id = id;
    e.st = 2'd0;
    e.d  = 32'd0;
    if (cxu != 4'd0) begin
      e.st = 2'd2;
    end else begin
      case (f)
        3'd0: e.d = a + b;
        3'd1: e.d = a ^ b;
        3'd2: e.d = 32'($countones(a));
        3'd3: begin macc[s] = macc[s] + a * b; e.d = macc[s]; end
        3'd4: e.d = macc[s];
        3'd5: begin e.d = macc[s]; macc[s] = a; end
        default: e.st = 2'd1;
      endcase
    end
    return e;
  endfunction

  task automatic send(logic [2:0] id, logic [3:0] cxu, logic [1:0] s,
                      logic [2:0] f, logic [31:0] a, logic [31:0] b);
    int w = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_id    = id;
    req_cxu   = cxu;
    req_state = s;
    req_func  = f;
    req_a     = a;
    req_b     = b;
    req_insn  = $urandom;
    #1;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!req_ready) begin
      chk("send_timeout", 0, 1);
      req_valid = 1'b0;
    end else begin
      acc_cyc = cyc;
      sbq.push_back(model(id, cxu, s, f, a, b));
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain_left", 64'(sbq.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: a handshake seen here completes at the next rising edge.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst && resp_valid && resp_ready) begin
      if (sbq.size() == 0) begin
        chk("resp_unexpected", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("resp_id", resp_id, mon_e.id);
        chk("resp_status", resp_status, mon_e.st);
        chk("resp_data", resp_data, mon_e.d);
      end
      pop_cyc.push_back(cyc);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rand_rr) resp_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    logic [31:0] held;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_status", resp_status, 0);
    chk("rst_resp_data", resp_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after_reset", req_ready, 1);

    resp_ready = 1'b1;
    send(3'd3, 4'd0, 2'd0, 3'd0, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    chk("add_not_early", resp_valid, 0);
    @(negedge clk);
    #3;
    chk("add_latency_valid", resp_valid, 1);
    chk("add_latency_cycles", 64'(cyc - acc_cyc), 2);
    drain();

    send(3'd0, 4'd0, 2'd1, 3'd5, 32'd10, 32'd0);
    send(3'd1, 4'd0, 2'd1, 3'd3, 32'd3, 32'd4);
    send(3'd2, 4'd0, 2'd1, 3'd3, 32'd5, 32'd5);
    send(3'd3, 4'd0, 2'd1, 3'd4, 32'd0, 32'd0);
    send(3'd4, 4'd0, 2'd0, 3'd4, 32'd0, 32'd0);
    idle(1);
    drain();

    send(3'd5, 4'd0, 2'd1, 3'd6, 32'd9, 32'd9);
    send(3'd6, 4'd5, 2'd1, 3'd6, 32'd9, 32'd9);
    send(3'd7, 4'd0, 2'd2, 3'd7, 32'd1, 32'd1);
    send(3'd0, 4'd5, 2'd1, 3'd3, 32'd7, 32'd7);
    send(3'd1, 4'd0, 2'd1, 3'd4, 32'd0, 32'd0);
    idle(1);
    drain();

    resp_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_id    = 3'(nacc);
      req_cxu   = 4'd0;
      req_state = 2'($urandom_range(0, 3));
      req_func  = 3'($urandom_range(0, 5));
      req_a     = $urandom;
      req_b     = $urandom;
      #1;
      if (req_ready) begin
        sbq.push_back(model(req_id, req_cxu, req_state, req_func,
                            req_a, req_b));
        nacc++;
      end
      if (i == 5) held = resp_data;
    end
    chk("bp_accepts", 64'(nacc), 4);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_resp_held", resp_valid, 1);
    chk("bp_head_id", resp_id, 0);
    chk("bp_data_stable", resp_data, held);
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("bp_ready_before_pop", req_ready, 0);
    @(negedge clk);
    #1;
    chk("bp_ready_reassert", req_ready, 1);
    drain();

    pop_cyc.delete();
    for (int k = 0; k < 16; k++)
      send(3'(k), 4'd0, 2'($urandom_range(0, 3)), 3'd2,
           (32'd1 << k) - 32'd1, $urandom);
    idle(1);
    drain();
    chk("stream_count", 64'(pop_cyc.size()), 16);
    for (int k = 1; k < pop_cyc.size(); k++)
      chk("stream_gap", 64'(pop_cyc[k] - pop_cyc[k-1]), 1);

    rand_rr = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(3'($urandom), ($urandom_range(0, 7) == 0) ?
           4'($urandom_range(1, 15)) : 4'd0,
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           $urandom, ($urandom_range(0, 1) == 0) ?
           32'($urandom_range(0, 15)) : $urandom);
    end
    idle(1);
    rand_rr = 1'b0;
    resp_ready = 1'b1;
    drain();

    resp_ready = 1'b0;
    send(3'd0, 4'd0, 2'd1, 3'd5, 32'd99, 32'd0);
    send(3'd1, 4'd0, 2'd2, 3'd3, 32'd6, 32'd7);
    send(3'd2, 4'd0, 2'd0, 3'd0, 32'd1, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_resp_data", resp_data, 0);
    sbq.delete();
    macc = '{default: 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    pop_cyc.delete();
    repeat (5) begin
      @(negedge clk);
      #3;
      chk("midrst_no_stale", resp_valid, 0);
    end
    chk("midrst_no_pops", 64'(pop_cyc.size()), 0);
    send(3'd3, 4'd0, 2'd1, 3'd4, 32'd0, 32'd0);
    send(3'd4, 4'd0, 2'd2, 3'd4, 32'd0, 32'd0);
    idle(1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
